// File: rtl/aes_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_sched_pkg : shared types for the AES job scheduler             |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package aes_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_KWAIT = 3'd2,
    ST_DATA  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef struct packed {
    logic         owner;
    logic         mode;
    logic [127:0] key;
    logic [127:0] din;
  } job_t;

endpackage
`default_nettype wire

// File: rtl/aes_rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_rr_arb2 : two-way round-robin arbiter, pointer moves on advance |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module aes_rr_arb2 (
  input  logic CLK,
  input  logic RSTn,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic gnt_a,
  output logic gnt_b
);

  // 1 = B was served last, so A wins the first tie after reset
  logic r_last_b;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_last_b <= 1'b1;
    end else if (advance) begin
      r_last_b <= gnt_b;
    end
  end

  assign gnt_a = req_a & (~req_b | r_last_b);
  assign gnt_b = req_b & (~req_a | ~r_last_b);

endmodule
`default_nettype wire

// File: rtl/aes_core_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_core_sched : job scheduler for shared-bus AES_ENC/AES_DEC cores |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         req_a,
  input  logic         mode_a,
  input  logic [127:0] key_a,
  input  logic [127:0] din_a,
  output logic         ack_a,
  output logic         vld_a,
  output logic         err_a,
  input  logic         req_b,
  input  logic         mode_b,
  input  logic [127:0] key_b,
  input  logic [127:0] din_b,
  output logic         ack_b,
  output logic         vld_b,
  output logic         err_b,
  output logic [127:0] dout,
  output logic [127:0] core_din,
  output logic [127:0] core_key,
  output logic         core_krdy,
  output logic         core_drdy,
  output logic         core_en_e,
  output logic         core_en_d,
  input  logic [127:0] core_dout_e,
  input  logic [127:0] core_dout_d,
  input  logic         core_bsy_e,
  input  logic         core_bsy_d,
  input  logic         core_dvld_e,
  input  logic         core_dvld_d
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t         r_state, w_next;
  job_t           r_job, w_new;
  logic [TW-1:0]  r_timer;
  logic [127:0]   r_cache_key [2];
  logic [1:0]     r_cache_vld;
  logic [127:0]   r_dout, r_core_key, r_core_din;
  logic           r_ack_a, r_ack_b;

  logic           w_gnt_a, w_gnt_b, w_fire, w_hit;
  logic           w_sel_bsy, w_sel_dvld, w_timeout, w_active;
  logic [127:0]   w_sel_dout;

  aes_rr_arb2 u_arb (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .req_a   (req_a),
    .req_b   (req_b),
    .advance (w_fire),
    .gnt_a   (w_gnt_a),
    .gnt_b   (w_gnt_b)
  );

  assign w_fire = (r_state == ST_IDLE) && (w_gnt_a || w_gnt_b);

  always_comb begin
    w_new.owner = w_gnt_b ? OWN_B : OWN_A;
    w_new.mode  = w_gnt_b ? mode_b : mode_a;
    w_new.key   = w_gnt_b ? key_b  : key_a;
    w_new.din   = w_gnt_b ? din_b  : din_a;
  end

  assign w_hit = KEY_CACHE && r_cache_vld[w_new.mode] &&
                 (r_cache_key[w_new.mode] == w_new.key);

  assign w_sel_bsy  = (r_job.mode == MODE_DEC) ? core_bsy_d  : core_bsy_e;
  assign w_sel_dvld = (r_job.mode == MODE_DEC) ? core_dvld_d : core_dvld_e;
  assign w_sel_dout = (r_job.mode == MODE_DEC) ? core_dout_d : core_dout_e;
  assign w_timeout  = (r_state == ST_RUN) && !w_sel_dvld && (r_timer == TMAX);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fire) w_next = w_hit ? ST_DATA : ST_KEY;
      ST_KEY:   w_next = ST_KWAIT;
      ST_KWAIT: if (!w_sel_bsy) w_next = ST_DATA;
      ST_DATA:  if (!w_sel_bsy) w_next = ST_RUN;
      ST_RUN: begin
        if (w_sel_dvld)             w_next = ST_DONE;
        else if (r_timer == TMAX)   w_next = ST_IDLE;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_job       <= '0;
      r_timer     <= '0;
      r_cache_vld <= '0;
      r_dout      <= '0;
      r_core_key  <= '0;
      r_core_din  <= '0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      for (int i = 0; i < 2; i++) r_cache_key[i] <= '0;
    end else begin
      r_ack_a <= w_fire & w_gnt_a;
      r_ack_b <= w_fire & w_gnt_b;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_job <= w_new;
            if (w_hit) r_core_din <= w_new.din;
            else       r_core_key <= w_new.key;
          end
        end
        ST_KWAIT: begin
          if (!w_sel_bsy) begin
            r_cache_key[r_job.mode] <= r_job.key;
            r_cache_vld[r_job.mode] <= 1'b1;
            r_core_din              <= r_job.din;
          end
        end
        ST_DATA: begin
          if (!w_sel_bsy) r_timer <= '0;
        end
        ST_RUN: begin
          if (w_sel_dvld) begin
            r_dout <= w_sel_dout;
          end else if (r_timer == TMAX) begin
            // core state is unknown after an abort, force a key reload
            r_cache_vld[r_job.mode] <= 1'b0;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_active  = (r_state != ST_IDLE);
  assign core_en_e = w_active && (r_job.mode == MODE_ENC);
  assign core_en_d = w_active && (r_job.mode == MODE_DEC);
  assign core_krdy = (r_state == ST_KEY);
  assign core_drdy = (r_state == ST_DATA) && !w_sel_bsy;
  assign core_key  = r_core_key;
  assign core_din  = r_core_din;
  assign dout      = r_dout;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign vld_a     = (r_state == ST_DONE) && (r_job.owner == OWN_A);
  assign vld_b     = (r_state == ST_DONE) && (r_job.owner == OWN_B);
  assign err_a     = w_timeout && (r_job.owner == OWN_A);
  assign err_b     = w_timeout && (r_job.owner == OWN_B);

endmodule
`default_nettype wire

// File: tb/tb_aes_core_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_aes_core_sched : directed bench with behavioural core stubs     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_aes_core_sched;

  localparam int TO   = 20;
  localparam int KLAT = 4;
  localparam int DLAT = 5;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KD = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P2 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] P3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] ME = {32{4'h5}};
  localparam logic [127:0] MD = {32{4'hc}};

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         req_a = 1'b0, mode_a = 1'b0, req_b = 1'b0, mode_b = 1'b0;
  logic [127:0] key_a = '0, din_a = '0, key_b = '0, din_b = '0;
  logic         ack_a, vld_a, err_a, ack_b, vld_b, err_b;
  logic [127:0] dout, core_din, core_key;
  logic         core_krdy, core_drdy, core_en_e, core_en_d;
  logic [127:0] core_dout_e = '0, core_dout_d = '0;
  logic         core_bsy_e, core_bsy_d;
  logic         core_dvld_e = 1'b0, core_dvld_d = 1'b0;

  always #5 CLK = ~CLK;

  aes_core_sched #(.TIMEOUT(TO), .KEY_CACHE(1'b1)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_a(req_a), .mode_a(mode_a), .key_a(key_a), .din_a(din_a),
    .ack_a(ack_a), .vld_a(vld_a), .err_a(err_a),
    .req_b(req_b), .mode_b(mode_b), .key_b(key_b), .din_b(din_b),
    .ack_b(ack_b), .vld_b(vld_b), .err_b(err_b),
    .dout(dout), .core_din(core_din), .core_key(core_key),
    .core_krdy(core_krdy), .core_drdy(core_drdy),
    .core_en_e(core_en_e), .core_en_d(core_en_d),
    .core_dout_e(core_dout_e), .core_dout_d(core_dout_d),
    .core_bsy_e(core_bsy_e), .core_bsy_d(core_bsy_d),
    .core_dvld_e(core_dvld_e), .core_dvld_d(core_dvld_d)
  );

  // Core stubs: return the reference vector for the known key/data, else a keyed XOR
  function automatic logic [127:0] f_enc(input logic [127:0] k, input logic [127:0] d);
    return (k == K0 && d == P0) ? C0 : (d ^ k ^ ME);
  endfunction
  function automatic logic [127:0] f_dec(input logic [127:0] k, input logic [127:0] d);
    return (k == KD && d == C0) ? P0 : (d ^ k ^ MD);
  endfunction

  logic [127:0] sk_e = '0, sk_d = '0, res_e = '0, res_d = '0;
  int           bc_e = 0, bc_d = 0;
  bit           pend_e = 1'b0, pend_d = 1'b0, hang_e = 1'b0;

  assign core_bsy_e = (bc_e != 0);
  assign core_bsy_d = (bc_d != 0);

  always @(posedge CLK) begin
    core_dvld_e <= 1'b0;
    if (bc_e > 0) begin
      bc_e <= bc_e - 1;
      if (bc_e == 1 && pend_e) begin
        pend_e <= 1'b0;
        if (!hang_e) begin
          core_dvld_e <= 1'b1;
          core_dout_e <= res_e;
        end
      end
    end else if (core_en_e && core_krdy) begin
      sk_e <= core_key;
      bc_e <= KLAT;
    end else if (core_en_e && core_drdy) begin
      res_e  <= f_enc(sk_e, core_din);
      bc_e   <= DLAT;
      pend_e <= 1'b1;
    end
  end

  always @(posedge CLK) begin
    core_dvld_d <= 1'b0;
    if (bc_d > 0) begin
      bc_d <= bc_d - 1;
      if (bc_d == 1 && pend_d) begin
        pend_d      <= 1'b0;
        core_dvld_d <= 1'b1;
        core_dout_d <= res_d;
      end
    end else if (core_en_d && core_krdy) begin
      sk_d <= core_key;
      bc_d <= KLAT;
    end else if (core_en_d && core_drdy) begin
      res_d  <= f_dec(sk_d, core_din);
      bc_d   <= DLAT;
      pend_d <= 1'b1;
    end
  end

  // Second instance without key caching, zero-latency stub core
  logic         req_a2 = 1'b0;
  logic [127:0] key_a2 = '0, din_a2 = '0;
  logic         ack_a2, vld_a2, err_a2, ack_b2, vld_b2, err_b2;
  logic [127:0] dout2, core_din2, core_key2;
  logic         core_krdy2, core_drdy2, core_en_e2, core_en_d2;
  logic [127:0] core_dout_e2 = '0;
  logic         core_dvld_e2 = 1'b0;

  aes_core_sched #(.TIMEOUT(TO), .KEY_CACHE(1'b0)) dut_nc (
    .CLK(CLK), .RSTn(RSTn),
    .req_a(req_a2), .mode_a(1'b0), .key_a(key_a2), .din_a(din_a2),
    .ack_a(ack_a2), .vld_a(vld_a2), .err_a(err_a2),
    .req_b(1'b0), .mode_b(1'b0), .key_b(128'h0), .din_b(128'h0),
    .ack_b(ack_b2), .vld_b(vld_b2), .err_b(err_b2),
    .dout(dout2), .core_din(core_din2), .core_key(core_key2),
    .core_krdy(core_krdy2), .core_drdy(core_drdy2),
    .core_en_e(core_en_e2), .core_en_d(core_en_d2),
    .core_dout_e(core_dout_e2), .core_dout_d(128'h0),
    .core_bsy_e(1'b0), .core_bsy_d(1'b0),
    .core_dvld_e(core_dvld_e2), .core_dvld_d(1'b0)
  );

  always @(posedge CLK) begin
    core_dvld_e2 <= core_drdy2 & core_en_e2;
    core_dout_e2 <= core_din2 ^ core_key2;
  end

  int           n_vec = 0, n_err = 0;
  int           cyc = 0, krdy_n, drdy_cyc, err_cyc, en_e_n, en_d_n, ack_n;
  logic [127:0] dout_a, dout_b;
  logic [15:0]  ord;
  bit           rearm_a = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance until n_done vld/err pulses are seen; ord logs A=1 B=2 errA=3 errB=4
  task automatic run(input int n_done, input int budget);
    int done = 0;
    krdy_n = 0; en_e_n = 0; en_d_n = 0; ack_n = 0; ord = '0;
    for (int i = 0; i < budget && done < n_done; i++) begin
      @(posedge CLK); #1; cyc++;
      if (core_krdy) krdy_n++;
      if (core_drdy) drdy_cyc = cyc;
      if (core_en_e) en_e_n++;
      if (core_en_d) en_d_n++;
      if (ack_a) begin
        ack_n++;
        if (rearm_a) begin rearm_a = 1'b0; din_a = P3; end
        else req_a = 1'b0;
      end
      if (ack_b) begin ack_n++; req_b = 1'b0; end
      if (vld_a) begin done++; ord = {ord[11:0], 4'h1}; dout_a = dout; end
      if (vld_b) begin done++; ord = {ord[11:0], 4'h2}; dout_b = dout; end
      if (err_a) begin done++; ord = {ord[11:0], 4'h3}; err_cyc = cyc; end
      if (err_b) begin done++; ord = {ord[11:0], 4'h4}; err_cyc = cyc; end
    end
    check_val("completion_budget", 128'(done), 128'(n_done));
  endtask

  task automatic job_a(input logic [127:0] k, input logic [127:0] d);
    req_a = 1'b1; mode_a = 1'b0; key_a = k; din_a = d;
    run(1, 200);
  endtask

  task automatic run_nc(input logic [127:0] k, input logic [127:0] d, output int kn);
    bit got = 1'b0;
    kn = 0;
    req_a2 = 1'b1; key_a2 = k; din_a2 = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge CLK); #1;
      if (ack_a2) req_a2 = 1'b0;
      if (core_krdy2) kn++;
      if (vld_a2) got = 1'b1;
    end
    check_val("nc_vld", 128'(got), 128'd1);
  endtask

  initial begin
    int  kn;
    int  late_n;
    bit  seen;

    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_ctrl", {ack_a, vld_a, err_a, ack_b, vld_b, err_b,
                           core_krdy, core_drdy, core_en_e, core_en_d}, '0);
    check_val("rst_dout", dout, '0);
    check_val("rst_bus", core_key | core_din, '0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    job_a(K0, P0);
    check_val("enc_ord", ord, 16'h1);
    check_val("enc_dout", dout_a, C0);
    check_val("enc_krdy", krdy_n, 1);
    check_val("enc_en_d_idle", en_d_n, 0);

    job_a(K0, P0);
    check_val("hit_dout", dout_a, C0);
    check_val("hit_krdy", krdy_n, 0);

    req_b = 1'b1; mode_b = 1'b1; key_b = KD; din_b = C0;
    run(1, 200);
    check_val("dec_ord", ord, 16'h2);
    check_val("dec_dout", dout_b, P0);
    check_val("dec_krdy", krdy_n, 1);
    check_val("dec_en_e_idle", en_e_n, 0);

    req_a = 1'b1; mode_a = 1'b0; key_a = K0; din_a = P1; rearm_a = 1'b1;
    req_b = 1'b1; mode_b = 1'b0; key_b = K0; din_b = P2;
    run(3, 400);
    check_val("tie_ord", ord, 16'h121);
    check_val("tie_acks", ack_n, 3);
    check_val("tie_dout_b", dout_b, P2 ^ K0 ^ ME);
    check_val("tie_dout_a", dout_a, P3 ^ K0 ^ ME);

    hang_e = 1'b1;
    job_a(K1, P1);
    check_val("to_ord", ord, 16'h3);
    check_val("to_delay", err_cyc - drdy_cyc, TO);
    check_val("to_krdy", krdy_n, 1);
    hang_e = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    job_a(K1, P1);
    check_val("reload_krdy", krdy_n, 1);
    check_val("reload_dout", dout_a, P1 ^ K1 ^ ME);

    req_a = 1'b1; mode_a = 1'b0; key_a = K0; din_a = P0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge CLK); #1;
      if (ack_a) req_a = 1'b0;
      if (core_drdy) seen = 1'b1;
    end
    check_val("mid_drdy_seen", 128'(seen), 128'd1);
    @(posedge CLK); #1;
    check_val("mid_running", core_en_e, 1'b1);
    RSTn = 1'b0;
    #1;
    check_val("mid_rst_ctrl", {ack_a, vld_a, err_a, core_krdy, core_drdy, core_en_e, core_en_d}, '0);
    check_val("mid_rst_dout", dout, '0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    late_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (vld_a || err_a) late_n++;
    end
    check_val("mid_no_result", late_n, 0);
    job_a(K0, P0);
    check_val("post_rst_krdy", krdy_n, 1);
    check_val("post_rst_dout", dout_a, C0);

    run_nc(K0, P0, kn);
    check_val("nc_first_krdy", kn, 1);
    run_nc(K0, P0, kn);
    check_val("nc_second_krdy", kn, 1);
    check_val("nc_dout", dout2, P0 ^ K0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
